// File: rtl/fir_job_ctrl.sv
// fir_job_ctrl: job sequencer for the FIR kernel. It latches the job length and
// coefficients on a start pulse and drives the kernel's ap_start. It admits
// exactly the programmed number of input samples and counts output samples.
// When the kernel has gone idle it emits a one-cycle completion event.
module fir_job_ctrl #(
  parameter int CNT_W   = 32,
  parameter int COEFF_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_start_i,
  input  logic                 cfg_clear_i,
  input  logic [CNT_W-1:0]     cfg_len_i,
  input  logic [4*COEFF_W-1:0] cfg_coeff_i,
  output logic [4*COEFF_W-1:0] coeff_o,
  output logic                 ap_start_o,
  input  logic                 ap_ready_i,
  input  logic                 ap_idle_i,
  input  logic                 ap_done_i,
  input  logic                 in_valid_i,
  input  logic                 in_ready_i,
  output logic                 in_valid_o,
  output logic                 in_ready_o,
  input  logic                 out_valid_i,
  input  logic                 out_ready_i,
  output logic                 busy_o,
  output logic                 done_evt_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     in_cnt_o,
  output logic [CNT_W-1:0]     out_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic [CNT_W-1:0]     r_len;
  logic [CNT_W-1:0]     r_in_cnt;
  logic [CNT_W-1:0]     r_out_cnt;
  logic [4*COEFF_W-1:0] r_coeff;
  logic                 r_err;
  logic                 r_done_evt;

  logic w_run;
  logic w_drain;
  logic w_busy;
  logic w_in_hs;
  logic w_out_hs;
  logic w_start_ok;
  logic w_in_last;
  logic w_unused_kernel;

  // The kernel's ap_ready/ap_done are informational; sequencing relies on
  // sample counts and ap_idle only.
  assign w_unused_kernel = ap_ready_i ^ ap_done_i;

  assign w_run      = (r_state == S_RUN);
  assign w_drain    = (r_state == S_DRAIN);
  assign w_busy     = w_run | w_drain;
  assign w_in_hs    = w_run & in_valid_i & in_ready_i;
  assign w_out_hs   = w_busy & out_valid_i & out_ready_i;
  assign w_start_ok = cfg_start_i & ~cfg_clear_i & (r_state == S_IDLE);
  assign w_in_last  = w_in_hs & (r_in_cnt == r_len - 1'b1);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a soft clear overrides everything and returns to IDLE
  always_comb begin
    w_next = r_state;
    if (cfg_clear_i) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (cfg_start_i) w_next = (cfg_len_i == '0) ? S_DONE : S_RUN;
        S_RUN:   if (w_in_last) w_next = S_DRAIN;
        S_DRAIN: if ((r_out_cnt == r_len) && ap_idle_i) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Job configuration latch; a zero-length job leaves the previous settings intact
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_len   <= '0;
      r_coeff <= '0;
    end else if (w_start_ok && (cfg_len_i != '0)) begin
      r_len   <= cfg_len_i;
      r_coeff <= cfg_coeff_i;
    end
  end

  // Sample counters, saturating at the job length and holding while idle
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (cfg_clear_i || w_start_ok) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_in_hs && (r_in_cnt != r_len))   r_in_cnt  <= r_in_cnt + 1'b1;
      if (w_out_hs && (r_out_cnt != r_len)) r_out_cnt <= r_out_cnt + 1'b1;
    end
  end

  // Sticky error: start while busy, or an output beyond the job length
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (cfg_clear_i || w_start_ok) begin
      r_err <= 1'b0;
    end else if ((cfg_start_i && w_busy) || (w_out_hs && (r_out_cnt == r_len))) begin
      r_err <= 1'b1;
    end
  end

  // Completion event registered from the DONE state; suppressed by a clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_done_evt <= 1'b0;
    else       r_done_evt <= (r_state == S_DONE) & ~cfg_clear_i;
  end

  assign coeff_o    = r_coeff;
  assign ap_start_o = w_run;
  assign busy_o     = w_busy;
  assign in_valid_o = w_run & in_valid_i;
  assign in_ready_o = w_run & in_ready_i;
  assign done_evt_o = r_done_evt;
  assign err_o      = r_err;
  assign in_cnt_o   = r_in_cnt;
  assign out_cnt_o  = r_out_cnt;

endmodule

// File: tb/tb_fir_job_ctrl.sv
// Bench for fir_job_ctrl: an upstream source and a one-cycle-latency kernel
// model surround the DUT. Expected per-job results are queued when a job is
// started and compared when done_evt_o fires.
module tb_fir_job_ctrl;
  localparam int CNT_W   = 32;
  localparam int COEFF_W = 16;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 cfg_start_i;
  logic                 cfg_clear_i;
  logic [CNT_W-1:0]     cfg_len_i;
  logic [4*COEFF_W-1:0] cfg_coeff_i;
  logic [4*COEFF_W-1:0] coeff_o;
  logic                 ap_start_o;
  logic                 ap_ready_i;
  logic                 ap_idle_i;
  logic                 ap_done_i;
  logic                 in_valid_i;
  logic                 in_ready_i;
  logic                 in_valid_o;
  logic                 in_ready_o;
  logic                 out_valid_i;
  logic                 out_ready_i;
  logic                 busy_o;
  logic                 done_evt_o;
  logic                 err_o;
  logic [CNT_W-1:0]     in_cnt_o;
  logic [CNT_W-1:0]     out_cnt_o;

  fir_job_ctrl #(.CNT_W(CNT_W), .COEFF_W(COEFF_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_start_i(cfg_start_i), .cfg_clear_i(cfg_clear_i),
    .cfg_len_i(cfg_len_i), .cfg_coeff_i(cfg_coeff_i), .coeff_o(coeff_o),
    .ap_start_o(ap_start_o), .ap_ready_i(ap_ready_i), .ap_idle_i(ap_idle_i),
    .ap_done_i(ap_done_i),
    .in_valid_i(in_valid_i), .in_ready_i(in_ready_i),
    .in_valid_o(in_valid_o), .in_ready_o(in_ready_o),
    .out_valid_i(out_valid_i), .out_ready_i(out_ready_i),
    .busy_o(busy_o), .done_evt_o(done_evt_o), .err_o(err_o),
    .in_cnt_o(in_cnt_o), .out_cnt_o(out_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned in_n;
    int unsigned out_n;
    bit          err;
  } job_t;

  job_t exp_q[$];
  int   n_chk     = 0;
  int   n_pass    = 0;
  int   avail     = 0;   // samples the upstream source still offers
  int   pending   = 0;   // samples inside the kernel model
  int   spur      = 0;   // extra outputs the kernel will emit in DRAIN
  int   up_cnt    = 0;   // upstream handshakes seen
  int   done_cnt  = 0;
  bit   hold_busy = 1'b0;
  bit   prev_done = 1'b0;

  logic [4*COEFF_W-1:0] c_a, c_b, c_c;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_model();
    in_valid_i  = (avail > 0);
    in_ready_i  = 1'b1;
    out_ready_i = 1'b1;
    out_valid_i = (pending > 0) || (spur > 0 && busy_o && !ap_start_o);
    ap_idle_i   = (pending == 0) && !hold_busy;
    ap_ready_i  = 1'b0;
    ap_done_i   = 1'b0;
  endtask

  // One clock: handshakes are taken from the values present at the edge,
  // then the model is updated and the scoreboard serviced at the negedge.
  task automatic tick();
    bit   hin, hout;
    job_t e;
    hin  = in_valid_i && in_ready_o;
    hout = out_valid_i && out_ready_i;
    @(posedge clk);
    #1;
    if (hout) begin
      if (pending > 0) pending--;
      else if (spur > 0) spur--;
    end
    if (hin) begin
      pending++;
      if (avail > 0) avail--;
      up_cnt++;
    end
    drive_model();
    @(negedge clk);
    if (done_evt_o) begin
      done_cnt++;
      check_eq("done_one_cycle", 64'(prev_done), 64'd0);
      if (exp_q.size() == 0) begin
        check_eq("done_unexpected", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("job_in_cnt", 64'(in_cnt_o), 64'(e.in_n));
        check_eq("job_out_cnt", 64'(out_cnt_o), 64'(e.out_n));
        check_eq("job_err", 64'(err_o), 64'(e.err));
      end
    end
    prev_done = done_evt_o;
  endtask

  task automatic start_job(input int unsigned len, input logic [4*COEFF_W-1:0] cf);
    cfg_start_i = 1'b1;
    cfg_len_i   = len;
    cfg_coeff_i = cf;
    drive_model();
    tick();
    cfg_start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    check_eq(tag, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic wait_in_cnt(input string tag, input int unsigned n);
    for (int i = 0; i < 60 && in_cnt_o != n; i++) tick();
    check_eq(tag, 64'(in_cnt_o), 64'(n));
  endtask

  initial begin
    int d0;
    c_a = {16'd4, 16'd3, 16'd2, 16'd1};
    c_b = {16'h0BAD, 16'h0CAF, 16'h00EE, 16'h1234};
    c_c = {16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
    rst_i = 1'b1; cfg_start_i = 1'b0; cfg_clear_i = 1'b0;
    cfg_len_i = '0; cfg_coeff_i = '0;
    drive_model();
    tick(); tick();
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_ap_start", 64'(ap_start_o), 64'd0);
    check_eq("rst_done_err", 64'({done_evt_o, err_o, in_ready_o, in_valid_o}), 64'd0);
    check_eq("rst_cnts", {in_cnt_o, out_cnt_o}, 64'd0);
    check_eq("rst_coeff", coeff_o, 64'd0);
    rst_i = 1'b0;
    tick();

    // len=4, continuous flow
    avail = 4;
    exp_q.push_back('{in_n: 4, out_n: 4, err: 1'b0});
    start_job(4, c_a);
    check_eq("t1_ap_start", 64'(ap_start_o), 64'd1);
    check_eq("t1_busy", 64'(busy_o), 64'd1);
    check_eq("t1_coeff", coeff_o, c_a);
    check_eq("t1_in_cnt0", 64'(in_cnt_o), 64'd0);
    wait_in_cnt("t1_in_cnt4", 4);
    check_eq("t1_in_ready_drop", 64'(in_ready_o), 64'd0);
    check_eq("t1_ap_start_drop", 64'(ap_start_o), 64'd0);
    wait_done("t1_done", 40);
    check_eq("t1_busy_fall", 64'(busy_o), 64'd0);
    tick();
    check_eq("t1_done_low", 64'(done_evt_o), 64'd0);

    // len=0: completion two cycles after the start pulse, kernel never started
    exp_q.push_back('{in_n: 0, out_n: 0, err: 1'b0});
    start_job(0, c_b);
    check_eq("t2_ap_start", 64'(ap_start_o), 64'd0);
    check_eq("t2_done_early", 64'(done_evt_o), 64'd0);
    tick();
    check_eq("t2_done_2cyc", 64'(done_evt_o), 64'd1);
    check_eq("t2_ap_start2", 64'(ap_start_o), 64'd0);
    check_eq("t2_coeff_kept", coeff_o, c_a);

    // len=3 while upstream offers 5 samples
    up_cnt = 0; avail = 5;
    exp_q.push_back('{in_n: 3, out_n: 3, err: 1'b0});
    start_job(3, c_b);
    wait_in_cnt("t3_in_cnt3", 3);
    check_eq("t3_drain_in_ready", 64'(in_ready_o), 64'd0);
    check_eq("t3_drain_in_valid", 64'(in_valid_o), 64'd0);
    wait_done("t3_done", 40);
    check_eq("t3_upstream_hs", 64'(up_cnt), 64'd3);
    check_eq("t3_left_over", 64'(avail), 64'd2);
    avail = 0; drive_model();

    // len=8 aborted by a clear after 5 inputs
    avail = 8;
    start_job(8, c_c);
    wait_in_cnt("t4_in_cnt5", 5);
    cfg_clear_i = 1'b1;
    tick();
    cfg_clear_i = 1'b0;
    check_eq("t4_busy", 64'(busy_o), 64'd0);
    check_eq("t4_in_cnt", 64'(in_cnt_o), 64'd0);
    check_eq("t4_out_cnt", 64'(out_cnt_o), 64'd0);
    check_eq("t4_ap_start", 64'(ap_start_o), 64'd0);
    check_eq("t4_coeff_kept", coeff_o, c_c);
    avail = 0; drive_model();
    d0 = done_cnt;
    for (int i = 0; i < 12; i++) tick();
    check_eq("t4_no_done", 64'(done_cnt - d0), 64'd0);

    // len=6 with a second start (len=10) arriving mid-job
    avail = 6;
    exp_q.push_back('{in_n: 6, out_n: 6, err: 1'b1});
    start_job(6, c_a);
    wait_in_cnt("t5_in_cnt2", 2);
    start_job(10, c_b);
    check_eq("t5_err", 64'(err_o), 64'd1);
    check_eq("t5_coeff_kept", coeff_o, c_a);
    check_eq("t5_busy", 64'(busy_o), 64'd1);
    wait_done("t5_done", 60);
    avail = 0; drive_model();

    // len=2 with a spurious third output while draining
    avail = 2; spur = 1; hold_busy = 1'b1;
    exp_q.push_back('{in_n: 2, out_n: 2, err: 1'b1});
    start_job(2, c_c);
    check_eq("t6_err_cleared", 64'(err_o), 64'd0);
    for (int i = 0; i < 40 && spur != 0; i++) tick();
    check_eq("t6_spur_sent", 64'(spur), 64'd0);
    check_eq("t6_err", 64'(err_o), 64'd1);
    check_eq("t6_out_cnt", 64'(out_cnt_o), 64'd2);
    check_eq("t6_still_busy", 64'(busy_o), 64'd1);
    hold_busy = 1'b0; drive_model();
    wait_done("t6_done", 20);

    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
